cgra0_conf_ctrl: RTL and testbench

CGRA0_CONF_CTRL -- requirements
Module: cgra0_conf_ctrl

---
 rtl/cgra0_pkg.sv | 20 ++
 rtl/cgra0_conf_ctrl_reg_pipe.sv | 28 ++
 rtl/cgra0_conf_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cgra0_conf_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra0_pkg.sv
// rtl/cgra0_pkg.sv - shared state encoding and default constants for the cgra0 configuration controller
//
// Contents:
//   state_t           controller FSM states
//   FLUSH_CYCLES_DEF  default conf-bus pipeline depth (input register plus four chained registers)

package cgra0_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_INIT  = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int FLUSH_CYCLES_DEF = 5;

endpackage

// File: rtl/cgra0_conf_ctrl_reg_pipe.sv
// rtl/cgra0_conf_ctrl_reg_pipe.sv - conf bus output register, zero when no word is valid
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   valid  in   data carries a configuration word this cycle
//   data   in   WIDTH  configuration word from memory
//   q      out  WIDTH  registered word, all-zero (no-op) when the word was not valid

module cgra0_conf_ctrl_reg_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= valid ? data : '0;
    end
  end

endmodule

// File: rtl/cgra0_conf_ctrl.sv
// rtl/cgra0_conf_ctrl.sv - loads CGRA configuration, flushes the conf pipeline, runs and counts output writes
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle configure-and-run request (IDLE only)
//   stop            abort request (RUN only)
//   num_conf        ADDR_WIDTH+1  number of configuration words, latched on start
//   num_out         CNT_WIDTH     expected output-FIFO writes, latched on start
//   conf_rd_en      config memory read strobe
//   conf_rd_addr    ADDR_WIDTH  config memory address
//   conf_rd_data    CONF_WIDTH  config memory data, one cycle after conf_rd_en
//   conf_bus_out    CONF_WIDTH  word driven to the CGRA conf bus, zero = no-op
//   fifo_out_we     CGRA output-FIFO write strobe
//   cgra_en         CGRA enable (RUN only)
//   cgra_rst        CGRA synchronous reset (INIT only)
//   busy            high outside IDLE
//   done            one-cycle completion pulse

module cgra0_conf_ctrl
  import cgra0_pkg::*;
#(
  parameter int CONF_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 8,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH:0]   num_conf,
  input  logic [CNT_WIDTH-1:0]  num_out,
  output logic                  conf_rd_en,
  output logic [ADDR_WIDTH-1:0] conf_rd_addr,
  input  logic [CONF_WIDTH-1:0] conf_rd_data,
  output logic [CONF_WIDTH-1:0] conf_bus_out,
  input  logic                  fifo_out_we,
  output logic                  cgra_en,
  output logic                  cgra_rst,
  output logic                  busy,
  output logic                  done
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1) + 1;
  localparam logic [ADDR_WIDTH:0]  ONE_A     = 1;
  localparam logic [CNT_WIDTH-1:0] ONE_C     = 1;
  localparam logic [FW-1:0]        ONE_F     = 1;
  localparam logic [FW-1:0]        FLUSH_END = FW'(FLUSH_CYCLES);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH:0]   num_conf_q;
  logic [CNT_WIDTH-1:0]  num_out_q;
  logic [ADDR_WIDTH:0]   load_cnt;
  logic [FW-1:0]         flush_cnt;
  logic [CNT_WIDTH-1:0]  out_cnt;
  logic                  rd_valid;
  logic                  load_last;
  logic                  out_hit;

  assign load_last = (load_cnt == (num_conf_q - ONE_A));

  // Completion is seen either from the already-reached count (covers num_out=0)
  // or from the write landing this cycle, so DONE follows the last write directly.
  assign out_hit = (out_cnt == num_out_q) ||
                   (fifo_out_we && ((out_cnt + ONE_C) == num_out_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    conf_rd_en   = 1'b0;
    conf_rd_addr = '0;
    cgra_en      = 1'b0;
    cgra_rst     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (num_conf != '0) ? ST_LOAD : ST_FLUSH;
        end
      end
      ST_LOAD: begin
        conf_rd_en   = 1'b1;
        conf_rd_addr = load_cnt[ADDR_WIDTH-1:0];
        if (load_last) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == FLUSH_END) begin
          state_next = ST_INIT;
        end
      end
      ST_INIT: begin
        cgra_rst   = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        cgra_en = 1'b1;
        if (out_hit || stop) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_conf_q <= '0;
      num_out_q  <= '0;
      load_cnt   <= '0;
      flush_cnt  <= '0;
      out_cnt    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= conf_rd_en;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            num_conf_q <= num_conf;
            num_out_q  <= num_out;
            load_cnt   <= '0;
            flush_cnt  <= '0;
            out_cnt    <= '0;
          end
        end
        ST_LOAD: begin
          load_cnt <= load_cnt + ONE_A;
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt + ONE_F;
        end
        ST_RUN: begin
          if (fifo_out_we && (out_cnt != num_out_q)) begin
            out_cnt <= out_cnt + ONE_C;
          end
        end
        default: begin
        end
      endcase
    end
  end

  cgra0_conf_ctrl_reg_pipe #(
    .WIDTH(CONF_WIDTH)
  ) u_reg_pipe (
    .clk  (clk),
    .rst  (rst),
    .valid(rd_valid),
    .data (conf_rd_data),
    .q    (conf_bus_out)
  );

endmodule

// File: tb/tb_cgra0_conf_ctrl.sv
// tb/tb_cgra0_conf_ctrl.sv - scenario bench for cgra0_conf_ctrl with a conf-word scoreboard

module tb_cgra0_conf_ctrl;

  localparam int CW = 64;
  localparam int AW = 8;
  localparam int FC = 5;
  localparam int NW = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic [AW:0]   num_conf;
  logic [NW-1:0] num_out;
  logic          conf_rd_en;
  logic [AW-1:0] conf_rd_addr;
  logic [CW-1:0] conf_rd_data;
  logic [CW-1:0] conf_bus_out;
  logic          fifo_out_we;
  logic          cgra_en;
  logic          cgra_rst;
  logic          busy;
  logic          done;

  logic [CW-1:0] mem [256];

  int vecs;
  int errs;

  cgra0_conf_ctrl #(
    .CONF_WIDTH  (CW),
    .ADDR_WIDTH  (AW),
    .FLUSH_CYCLES(FC),
    .CNT_WIDTH   (NW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .num_conf    (num_conf),
    .num_out     (num_out),
    .conf_rd_en  (conf_rd_en),
    .conf_rd_addr(conf_rd_addr),
    .conf_rd_data(conf_rd_data),
    .conf_bus_out(conf_bus_out),
    .fifo_out_we (fifo_out_we),
    .cgra_en     (cgra_en),
    .cgra_rst    (cgra_rst),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) conf_rd_data <= mem[conf_rd_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vecs++;
    if ({conf_rd_en, conf_rd_addr, conf_bus_out, cgra_en, cgra_rst, busy, done} !== '0) begin
      errs++;
      $display("FAIL reset_state got en=%b addr=%0d bus=%h cen=%b crst=%b busy=%b done=%b exp all 0",
               conf_rd_en, conf_rd_addr, conf_bus_out, cgra_en, cgra_rst, busy, done);
    end
    rst = 1'b0;
    step();
    vecs++;
    if ({conf_rd_en, busy, done, cgra_en} !== 4'b0) begin
      errs++;
      $display("FAIL reset_release got en=%b busy=%b done=%b cen=%b exp 0", conf_rd_en, busy, done, cgra_en);
    end
  endtask

  // One full transaction: checks every output each cycle against the timing
  // model; conf words go through a due-cycle scoreboard.
  task automatic test_transaction(input string name, input int nconf, input int nout,
                                  input logic [31:0] we_mask, input int stop_off, input int start_off);
    logic [CW-1:0] q_data[$];
    int            q_due[$];
    int            init_c, run_c, done_at, m_cnt, c, off;
    bit            finished;
    logic          e_rd, e_rst, e_en, e_done, e_busy;
    logic [AW-1:0] e_addr;
    logic [CW-1:0] e_bus;
    init_c   = nconf + FC + 2;
    run_c    = init_c + 1;
    done_at  = -1;
    m_cnt    = 0;
    finished = 1'b0;
    num_conf = (AW+1)'(nconf);
    num_out  = NW'(nout);
    start    = 1'b1;
    step();
    start = 1'b0;
    for (c = 1; c <= run_c + 60; c++) begin
      e_rd   = (c <= nconf);
      e_addr = e_rd ? AW'(c - 1) : '0;
      if (e_rd) begin
        q_data.push_back(mem[c-1]);
        q_due.push_back(c + 2);
      end
      e_bus = '0;
      if (q_due.size() > 0 && q_due[0] == c) begin
        e_bus = q_data.pop_front();
        void'(q_due.pop_front());
      end
      e_rst  = (c == init_c);
      e_en   = (c >= run_c) && (done_at < 0 || c < done_at);
      e_done = (c == done_at);
      e_busy = (done_at < 0) || (c <= done_at);
      vecs += 7;
      if (conf_rd_en !== e_rd) begin
        errs++; $display("FAIL %s c%0d conf_rd_en got %b exp %b", name, c, conf_rd_en, e_rd);
      end
      if (conf_rd_addr !== e_addr) begin
        errs++; $display("FAIL %s c%0d conf_rd_addr got %0d exp %0d", name, c, conf_rd_addr, e_addr);
      end
      if (conf_bus_out !== e_bus) begin
        errs++; $display("FAIL %s c%0d conf_bus_out got %h exp %h", name, c, conf_bus_out, e_bus);
      end
      if (cgra_rst !== e_rst) begin
        errs++; $display("FAIL %s c%0d cgra_rst got %b exp %b", name, c, cgra_rst, e_rst);
      end
      if (cgra_en !== e_en) begin
        errs++; $display("FAIL %s c%0d cgra_en got %b exp %b", name, c, cgra_en, e_en);
      end
      if (done !== e_done) begin
        errs++; $display("FAIL %s c%0d done got %b exp %b", name, c, done, e_done);
      end
      if (busy !== e_busy) begin
        errs++; $display("FAIL %s c%0d busy got %b exp %b", name, c, busy, e_busy);
      end
      if (done_at >= 0 && c > done_at) begin
        finished = 1'b1;
        break;
      end
      off         = c - run_c;
      fifo_out_we = (c == 1) || (e_en && off < 32 && we_mask[off]);
      stop        = e_en && (off == stop_off);
      start       = e_en && (off == start_off);
      if (start) begin
        num_conf = 9'd7;
        num_out  = 32'd1;
      end
      if (e_en) begin
        if (m_cnt == nout || (fifo_out_we && m_cnt + 1 == nout) || stop) done_at = c + 1;
        if (fifo_out_we && m_cnt < nout) m_cnt++;
      end
      step();
    end
    fifo_out_we = 1'b0;
    stop        = 1'b0;
    start       = 1'b0;
    vecs++;
    if (!finished) begin
      errs++;
      $display("FAIL %s timeout got no return to IDLE exp done by cycle %0d", name, done_at);
    end
  endtask

  task automatic test_basic();
    test_transaction("basic", 3, 2, 32'b1_0100, -1, -1);
  endtask

  task automatic test_no_conf();
    test_transaction("no_conf", 0, 1, 32'b1000, -1, -1);
  endtask

  task automatic test_stop();
    test_transaction("stop", 4, 10, 32'b0011, 3, -1);
  endtask

  task automatic test_zero_out();
    test_transaction("zero_out", 2, 0, 32'b0, -1, -1);
  endtask

  task automatic test_start_in_run();
    test_transaction("start_in_run", 1, 3, 32'b10_1100, -1, 1);
  endtask

  task automatic test_idle_writes();
    for (int i = 0; i < 6; i++) begin
      fifo_out_we = (i % 2 == 0);
      step();
      vecs++;
      if ({busy, conf_rd_en, cgra_en, cgra_rst, done} !== 5'b0) begin
        errs++;
        $display("FAIL idle_writes i%0d got busy=%b rd=%b cen=%b crst=%b done=%b exp 0",
                 i, busy, conf_rd_en, cgra_en, cgra_rst, done);
      end
    end
    fifo_out_we = 1'b0;
    test_transaction("after_idle_writes", 2, 2, 32'b0101, -1, -1);
  endtask

  task automatic test_reset_mid_load();
    num_conf = 9'd5;
    num_out  = 32'd4;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    vecs++;
    if (conf_rd_addr !== 8'd2) begin
      errs++; $display("FAIL mid_load_addr got %0d exp 2", conf_rd_addr);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({conf_rd_en, conf_rd_addr, conf_bus_out, cgra_en, cgra_rst, busy, done} !== '0) begin
      errs++;
      $display("FAIL mid_load_reset got en=%b addr=%0d bus=%h cen=%b crst=%b busy=%b done=%b exp all 0",
               conf_rd_en, conf_rd_addr, conf_bus_out, cgra_en, cgra_rst, busy, done);
    end
    step();
    rst = 1'b0;
    step();
    test_transaction("reload", 2, 1, 32'b1, -1, -1);
  endtask

  initial begin
    vecs        = 0;
    errs        = 0;
    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    fifo_out_we = 1'b0;
    num_conf    = '0;
    num_out     = '0;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom(), $urandom()} | 64'h1;
    test_reset();
    test_basic();
    test_no_conf();
    test_stop();
    test_zero_out();
    test_start_in_run();
    test_idle_writes();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
